// File: rtl/xpb_accum_seq.sv
// xpb_accum_seq: issues one xpb table lookup per digit and accumulates the
// registered table outputs onto a base value.
module xpb_accum_seq #(
  parameter int DIGIT_W    = 5,
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 1024,
  parameter int ACC_W      = 1028,
  parameter int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] upper_in,
  input  logic [ACC_W-1:0]              base_in,
  output logic                          ready,
  output logic                          tbl_req,
  output logic [SEL_W-1:0]              tbl_sel,
  output logic [DIGIT_W-1:0]            tbl_digit,
  input  logic [DATA_W-1:0]             tbl_data,
  output logic                          done,
  output logic [ACC_W-1:0]              sum_out
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int UP_W = NUM_DIGITS * DIGIT_W;

  logic [1:0]       state_q, state_d;
  logic [UP_W-1:0]  sh_q, sh_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, acc_add;
  logic             pend_q, pend_d;
  logic             accept, is_issue, last;

  // pend_q marks the cycle where the table answers the previous lookup
  always_comb begin
    is_issue = state_q == S_ISSUE;
    accept   = start && ready;
    last     = cnt_q == SEL_W'(NUM_DIGITS - 1);
    acc_add  = acc_q + ACC_W'(tbl_data);
    state_d  = accept ? S_ISSUE :
               is_issue ? (last ? S_DRAIN : S_ISSUE) :
               state_q == S_DRAIN ? S_DONE : S_IDLE;
    sh_d     = accept ? upper_in : is_issue ? sh_q >> DIGIT_W : sh_q;
    cnt_d    = accept ? '0 : is_issue ? cnt_q + SEL_W'(1) : cnt_q;
    acc_d    = accept ? base_in : pend_q ? acc_add : acc_q;
    sum_d    = state_q == S_DRAIN ? acc_add : sum_q;
    pend_d   = is_issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      pend_q  <= pend_d;
    end
  end

  assign ready     = state_q == S_IDLE || state_q == S_DONE;
  assign done      = state_q == S_DONE;
  assign tbl_req   = is_issue;
  assign tbl_sel   = is_issue ? cnt_q : '0;
  assign tbl_digit = is_issue ? sh_q[DIGIT_W-1:0] : '0;
  assign sum_out   = sum_q;
endmodule

// File: tb/tb_xpb_accum_seq.sv
// tb_xpb_accum_seq: directed requests against a registered (sel+1)*digit ROM,
// with a request-level model checked every cycle plus literal sum/latency pins.
module tb_xpb_accum_seq;
  localparam int DW = 5, ND = 8, DATA_W = 1024, ACC_W = 1028, SW = 3;

  logic              clk = 0, rst_n = 0, start = 0, garb = 0;
  logic [ND*DW-1:0]  upper_in = '0;
  logic [ACC_W-1:0]  base_in = '0;
  logic              ready, tbl_req, done;
  logic [SW-1:0]     tbl_sel;
  logic [DW-1:0]     tbl_digit;
  logic [DATA_W-1:0] tbl_data = '0;
  logic [ACC_W-1:0]  sum_out;
  int checks = 0, errors = 0, cyc = 0;

  xpb_accum_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .upper_in(upper_in),
    .base_in(base_in), .ready(ready), .tbl_req(tbl_req), .tbl_sel(tbl_sel),
    .tbl_digit(tbl_digit), .tbl_data(tbl_data), .done(done), .sum_out(sum_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: answers one cycle after a lookup, garbage otherwise when enabled
  always @(posedge clk)
    tbl_data <= tbl_req ? DATA_W'((32'(tbl_sel) + 1) * 32'(tbl_digit)) :
                garb ? {32{$urandom}} : '0;

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h_%h exp=%h_%h", name, act[1027:1024], act[127:0], exp[1027:1024], exp[127:0]);
    end
  endtask

  // Model: ph = cycles since acceptance (-1 idle); expected sum computed up front
  int               ph = -1;
  logic [ND*DW-1:0] m_up;
  logic [ACC_W-1:0] m_pend, m_sum = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = -1;
      m_sum = '0;
    end else if ((ph < 0 || ph == ND + 1) && start) begin
      ph = 0;
      m_up = upper_in;
      m_pend = base_in;
      for (int k = 0; k < ND; k++) m_pend += ACC_W'((k + 1) * int'(upper_in[k*DW +: DW]));
    end else if (ph >= 0 && ph < ND + 1) begin
      ph++;
      if (ph == ND + 1) m_sum = m_pend;
    end else ph = -1;
  end

  always @(negedge clk) if (rst_n) begin
    chk("ready", ACC_W'(ready), ACC_W'(ph < 0 || ph == ND + 1));
    chk("done", ACC_W'(done), ACC_W'(ph == ND + 1));
    chk("tbl_req", ACC_W'(tbl_req), ACC_W'(ph >= 0 && ph < ND));
    chk("tbl_sel", ACC_W'(tbl_sel), (ph >= 0 && ph < ND) ? ACC_W'(ph) : '0);
    chk("tbl_digit", ACC_W'(tbl_digit), (ph >= 0 && ph < ND) ? ACC_W'(m_up[ph*DW +: DW]) : '0);
    chk("sum_out", sum_out, m_sum);
  end

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 20 && c < 0; i++) begin
      @(negedge clk);
      if (done) c = cyc;
    end
    if (c < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic launch(input logic [ND*DW-1:0] up, input logic [ACC_W-1:0] b, output int c0);
    @(negedge clk);
    upper_in = up; base_in = b; start = 1;
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_req(input string name, input logic [ND*DW-1:0] up, input logic [ACC_W-1:0] b,
                         input logic [ACC_W-1:0] exp);
    int c0, cd;
    launch(up, b, c0);
    wait_done(cd);
    chk({name, "_latency"}, ACC_W'(cd - c0), ACC_W'(ND + 1));
    chk({name, "_sum"}, sum_out, exp);
  endtask

  initial begin
    int c0, d1, d2;
    logic [ND*DW-1:0] ramp;
    for (int k = 0; k < ND; k++) ramp[k*DW +: DW] = DW'(k);
    #1;
    chk("rst_ready", ACC_W'(ready), 1);
    chk("rst_done", ACC_W'(done), 0);
    chk("rst_req", ACC_W'(tbl_req), 0);
    chk("rst_sum", sum_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_req("ones", {ND{5'd1}}, '0, 36);
    garb = 1;
    run_req("big", {ND{5'd31}}, (ACC_W'(1) << 1027) - 100, (ACC_W'(1) << 1027) + 1016);
    run_req("zero", '0, 'h1234, 'h1234);
    // request A with a stray start mid-issue, then B started in A's done cycle
    launch({ND{5'd2}}, 7, c0);
    repeat (3) @(negedge clk);
    start = 1; base_in = 999; upper_in = {ND{5'd31}};
    @(negedge clk);
    start = 0;
    wait_done(d1);
    chk("a_sum", sum_out, 79);
    upper_in = ramp; base_in = 5; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(d2);
    chk("b2b_gap", ACC_W'(d2 - d1), 10);
    chk("b_sum", sum_out, 173);
    // asynchronous abort in issue cycle 4
    launch({ND{5'd3}}, 10, c0);
    for (int i = 0; i < 10 && tbl_sel != 3'd4; i++) @(negedge clk);
    chk("abort_sel", ACC_W'(tbl_sel), 4);
    #2 rst_n = 0;
    #1;
    chk("abort_ready", ACC_W'(ready), 1);
    chk("abort_req", ACC_W'(tbl_req), 0);
    chk("abort_sel0", ACC_W'(tbl_sel), 0);
    chk("abort_digit", ACC_W'(tbl_digit), 0);
    chk("abort_sum", sum_out, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_done", ACC_W'(done), 0);
    end
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_abort_done", ACC_W'(done), 0);
    end
    run_req("fresh", {ND{5'd1}}, 100, 136);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xpb_accum_seq.md
# xpb_accum_seq

Sequencer that reduces a wide upper word by time-multiplexing one shared set of xpb lookup tables. It slices the upper word into DIGIT_W-bit digits, presents one digit per cycle to the table port with a segment select, and accumulates the returned DATA_W-bit precomputed values onto a base value. It sits between the modular-square datapath, which supplies the upper bits and base, and the xpb ROM bank, which is registered with 1-cycle latency.

## Interface
- DIGIT_W, 5, bits per lookup digit (table index width)
- NUM_DIGITS, 8, digits per request (segments sequenced)
- DATA_W, 1024, table entry width
- ACC_W, 1028, accumulator width; must be at least DATA_W + clog2(NUM_DIGITS+1)
- SEL_W, clog2(NUM_DIGITS), segment select width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; accepted only when ready=1
- upper_in  in  NUM_DIGITS*DIGIT_W  upper word; digit k = bits [k*DIGIT_W +: DIGIT_W], LSB-first
- base_in  in  ACC_W  initial accumulator value
- ready  out  1  high in IDLE and DONE
- tbl_req  out  1  high while a digit is presented
- tbl_sel  out  SEL_W  segment/table select for current digit
- tbl_digit  out  DIGIT_W  table index
- tbl_data  in  DATA_W  table output, valid the cycle after tbl_req
- done  out  1  one-cycle pulse, sum_out valid
- sum_out  out  ACC_W  final accumulated sum, held until next done

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: ready=1, tbl_req=0, tbl_sel=0, tbl_digit=0. start=1 captures upper_in into a digit shift register, base_in into acc, clears the digit counter, and moves to ISSUE.
- ISSUE: lasts NUM_DIGITS cycles. In issue cycle k, tbl_req=1, tbl_sel=k, and tbl_digit=digit k. Data for digit k-1 arrives in the same cycle and is added at the clock edge: acc <= acc + zero-extend(tbl_data). At the edge ending issue cycle NUM_DIGITS-1, move to DRAIN.
- DRAIN: lasts 1 cycle. tbl_req=0, tbl_digit=0. The last digit's data is added. Move to DONE. At the same edge, sum_out is loaded with the final sum.
- DONE: lasts 1 cycle. done=1, ready=1. start=1 accepts a new request and moves to ISSUE. Otherwise move to IDLE.
- Adds are taken only on the edge following a cycle with tbl_req=1. tbl_data is ignored in all other cycles.
- Addition wraps modulo 2^ACC_W. With legal parameters, no overflow is possible.
- start while busy (ISSUE or DRAIN) is ignored, with no queuing.
- Zero digits are still issued; there is no skipping, so latency is fixed.

## Timing
- Start accepted at edge E0. Digit k is issued in cycle E0+k, with E(k+1) being the next edge. Its data is valid in cycle E0+k+1 and added at edge E(k+2).
- The final add occurs at edge E(NUM_DIGITS+1). done is high during cycle E0+NUM_DIGITS+1, i.e. NUM_DIGITS+1 cycles after the start cycle (9 for defaults).
- Back-to-back throughput is one request per NUM_DIGITS+2 cycles when start is asserted in the DONE cycle.
- Reset values: state=IDLE, ready=1, done=0, tbl_req=0, tbl_sel=0, tbl_digit=0, sum_out=0, acc=0.
- Reset asserted mid-operation aborts immediately. No done is produced for the aborted request. After release, the block is in IDLE.
- sum_out changes only when done is asserted or on reset.

## Test plan
- Behavioural ROM model (registered, 1-cycle latency) returning (sel+1)*digit. Input: base 0, all 8 digits = 1. Expected: tbl_sel sequence 0..7 in consecutive cycles, done 9 cycles after start, sum_out = 36.
- Input: base = 2^1027 - 100, all digits 31. Expected: sum = base + 31*36 = 2^1027 + 1016, with no truncation in ACC_W=1028.
- Input: upper_in = 0, base = 0x1234. Expected: tbl_digit is 0 for all 8 issue cycles, latency unchanged, sum_out = 0x1234.
- Assert start again in the DONE cycle. Expected: the second request is accepted with no idle gap, and the two done pulses are exactly 10 cycles apart. Also: a start pulse in cycles 1..8 of a request is ignored.
- Drop rst_n during issue cycle 4. Expected: done is never raised, all outputs go to reset values asynchronously, and a fresh request after release yields the correct sum.
- Drive tbl_data with garbage in every cycle where it is not valid. Expected: sum_out is unaffected.
